// File: rtl/wb_write_queue.sv
// Register-file write-back stage: merges a no-backpressure ALU result path with a
// FIFO-buffered load path and exports per-register pending flags. Optional macro: WB_BYPASS_EN.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [4:0]    a_reg,
    input  logic [31:0]   a_data,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [4:0]    m_reg,
    input  logic [31:0]   m_data,
    output logic          RegWrite,
    output logic [4:0]    WriteReg,
    output logic [31:0]   WriteData,
    input  logic [4:0]    chk_reg1,
    input  logic [4:0]    chk_reg2,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [4:0]       ent_reg  [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_kill;
    logic [DEPTH-1:0] live;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic head_valid;
    logic a_kills;
    logic bypass;
    logic push;
    logic pop;

    assign head_valid = (count != '0);
    assign a_kills    = a_valid && (a_reg != 5'd0);
    assign m_ready    = rst && (count < FULL);

`ifdef WB_BYPASS_EN
    // An empty queue with an idle ALU lets the load result go straight to the output stage.
    assign bypass = m_valid && m_ready && !a_valid && !head_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = m_valid && m_ready && !bypass;
    assign pop  = !a_valid && head_valid;

    // NOTE: payload storage has no reset; liveness comes from the pointers and count,
    // so only control state (pointers, count, kill bits) needs clearing.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[wr_ptr]  <= m_reg;
            ent_data[wr_ptr] <= m_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ent_kill <= '0;
        end else begin
            // A newer ALU write to the same register supersedes every queued load.
            for (int i = 0; i < DEPTH; i++) begin
                if (a_kills && (ent_reg[i] == a_reg)) ent_kill[i] <= 1'b1;
            end
            if (push) begin
                ent_kill[wr_ptr] <= a_kills && (m_reg == a_reg);
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (a_valid) begin
            RegWrite  <= (a_reg != 5'd0);
            WriteReg  <= a_reg;
            WriteData <= a_data;
        end else if (bypass) begin
            RegWrite  <= (m_reg != 5'd0);
            WriteReg  <= m_reg;
            WriteData <= m_data;
        end else if (head_valid) begin
            RegWrite  <= !ent_kill[rd_ptr] && (ent_reg[rd_ptr] != 5'd0);
            WriteReg  <= ent_reg[rd_ptr];
            WriteData <= ent_data[rd_ptr];
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // NOTE: each always_comb output gets a default first so no path infers a latch.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, AW'(i) - rd_ptr} < count);
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && !ent_kill[i]) begin
                if (ent_reg[i] == chk_reg1) busy1 = 1'b1;
                if (ent_reg[i] == chk_reg2) busy2 = 1'b1;
            end
        end
        if (RegWrite && (WriteReg == chk_reg1)) busy1 = 1'b1;
        if (RegWrite && (WriteReg == chk_reg2)) busy2 = 1'b1;
        if (a_valid && (a_reg == chk_reg1)) busy1 = 1'b1;
        if (a_valid && (a_reg == chk_reg2)) busy2 = 1'b1;
        if (chk_reg1 == 5'd0) busy1 = 1'b0;
        if (chk_reg2 == 5'd0) busy2 = 1'b0;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back side of the CPU register file. Drives the register file's single write port (RegWrite, WriteReg, WriteData).
- Merges two result sources:
  - the single-cycle ALU result path, which has no backpressure;
  - the long-latency load/multi-cycle result path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Exports per-register pending flags so decode can stall reads of registers whose writes are still in flight.

Parameters:
DEPTH, 4, FIFO entries for the load path (power of two, ≥2)
AW, 2, log2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
a_valid  input  1  ALU result valid this cycle; always accepted
a_reg  input  5  ALU destination register
a_data  input  32  ALU result
m_valid  input  1  load result valid
m_ready  output  1  FIFO can accept; high when not full
m_reg  input  5  load destination register
m_data  input  32  load result
RegWrite  output  1  register-file write enable (registered)
WriteReg  output  5  register-file write address (registered)
WriteData  output  32  register-file write data (registered)
chk_reg1  input  5  decode read address 1
chk_reg2  input  5  decode read address 2
busy1  output  1  chk_reg1 has a pending write
busy2  output  1  chk_reg2 has a pending write
count  output  AW+1  live FIFO occupancy (0..DEPTH)

Behaviour:
- Reset (rst low, asynchronous):
  - RegWrite=0, WriteReg=0, WriteData=0.
  - FIFO empty: pointers=0, count=0, all entry kill bits cleared.
  - m_ready=1 once rst is released.
- Output stage register holds exactly one write per cycle. Source priority for the next output:
  1. a_valid
  2. FIFO head (if not empty)
  3. otherwise idle, RegWrite=0
- ALU latency: a_valid sampled at edge N, so RegWrite=1 with a_reg/a_data during cycle N..N+1. The register file commits at edge N+1.
- Load path handshake:
  - Transfer occurs when m_valid && m_ready at a rising edge.
  - m_ready = (count < DEPTH), combinational from state only.
  - m_valid held while m_ready=0 is not a transfer.
  - Enqueued entry is drained no earlier than the edge after enqueue, so minimum latency is 2 cycles.
- Register 0:
  - Writes to reg 0 from either source are accepted.
  - They produce RegWrite=0 at the output stage (slot consumed, no write).
  - busy flags never assert for chk_regX=0.
- Drain:
  - FIFO head pops on an edge where a_valid=0 and count>0.
  - Killed head pops with RegWrite=0.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Write-after-write, ALU newer:
  - On an edge with a_valid and a_reg≠0, every FIFO entry whose reg equals a_reg gets its kill bit set.
  - An entry being enqueued on the same edge with m_reg==a_reg is also stored killed. The load is defined as older.
  - Killed entries still occupy FIFO space until drained.
- busy1/busy2 (combinational) assert when chk_regX≠0 and any of the following hold:
  - a non-killed live FIFO entry matches;
  - the output stage has RegWrite=1 and WriteReg matches;
  - a_valid=1 and a_reg matches.
- FIFO full with a_valid continuously high: the FIFO does not drain and m_ready stays 0. No loss, no overflow.
- Reset mid-operation discards all pending entries and the output stage immediately. No partial write is issued after release.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when count==0, a_valid=0 and an m transfer occurs, the load result loads the output stage directly on that edge, skipping the FIFO. Latency is 1 cycle and count stays 0.
- Not defined: every load transfer enqueues, with a minimum latency of 2 cycles.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 with random inputs → RegWrite=0, WriteReg=0, WriteData=0, count=0, m_ready=0→1 after release.
- ALU write: a_valid=1, a_reg=5, a_data=0xDEADBEEF for one cycle → next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; busy1=1 for chk_reg1=5 until that cycle ends.
- Load through FIFO (no bypass build): push reg 7 = 0x11 → RegWrite with 7/0x11 two cycles later. Push 4 entries with a_valid held high → count=4, m_ready=0. Release a_valid → entries drain one per cycle in order and count returns to 0.
- WAW kill: enqueue reg 9 = 0xAA, same cycle a_valid reg 9 = 0xBB → output writes 0xBB. The later drained slot shows RegWrite=0, so the final value of reg 9 is 0xBB.
- Reg 0: a_valid a_reg=0 and a load to reg 0 → no RegWrite pulses, busy1=0 for chk_reg1=0.
- WB_BYPASS_EN build: empty FIFO, idle ALU, load reg 3 = 0x42 → RegWrite 3/0x42 on the next cycle, count stays 0.
